// File: rtl/led_seq_pkg.sv
// led_seq_pkg -- shared types and constants for the LED sequencer.
//   state_e    : controller states (IDLE / RUN / PAUSE)
//   dir_e      : bounce direction (up = towards bit WIDTH-1)
//   MODE_*     : encodings of the mode input
//   EDGE_CNT_W : prescaler counter width, wide enough for STEP_DIV up to 16
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic MODE_ROT    = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam int EDGE_CNT_W = 5;

endpackage

// File: rtl/led_seq_if.sv
// led_seq_if -- control/status bundle of the LED sequencer.
//   tick_in, start, stop, mode : driven by the master (controller side)
//   led, busy, step_pulse      : driven by the slave (led_seq)
//   pass_cnt                   : present only with LED_SEQ_PASS_CNT_EN defined
interface led_seq_if #(
  parameter int WIDTH = 8
);

  logic             tick_in;
  logic             start;
  logic             stop;
  logic             mode;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             step_pulse;
`ifdef LED_SEQ_PASS_CNT_EN
  logic [7:0]       pass_cnt;

  modport master (
    output tick_in, start, stop, mode,
    input  led, busy, step_pulse, pass_cnt
  );

  modport slave (
    input  tick_in, start, stop, mode,
    output led, busy, step_pulse, pass_cnt
  );
`else
  modport master (
    output tick_in, start, stop, mode,
    input  led, busy, step_pulse
  );

  modport slave (
    input  tick_in, start, stop, mode,
    output led, busy, step_pulse
  );
`endif

endinterface

// File: rtl/led_seq_edge_tick.sv
// edge_tick -- rising-edge detector and STEP_DIV prescaler for the divider
// square wave.
//   clk, rst : clock and asynchronous active-low reset
//   tick_in  : divider output (already registered in this clock domain)
//   enable   : count edges only while high
//   clear    : restart the prescaler at zero
//   step     : combinational, high in the cycle of every STEP_DIV-th counted edge
module edge_tick
  import led_seq_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  input  logic enable,
  input  logic clear,
  output logic step
);

  logic                  tick_d_q, tick_d_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  edge_w;
  logic                  last_w;

  always_comb begin
    tick_d_d = tick_in;
    edge_w   = tick_in & ~tick_d_q;
    last_w   = (edge_cnt_q == EDGE_CNT_W'(STEP_DIV - 1));
    // enable and clear are never high together (clear only fires outside RUN)
    step     = enable & edge_w & last_w;

    edge_cnt_d = edge_cnt_q;
    if (clear) begin
      edge_cnt_d = '0;
    end else if (enable && edge_w) begin
      edge_cnt_d = last_w ? '0 : edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_d_q   <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      tick_d_q   <= tick_d_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

endmodule

// File: rtl/led_seq.sv
// led_seq -- one-hot LED pattern sequencer (rotate / bounce) stepped by the
// clock-divider square wave.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : led_seq_if slave -- tick_in/start/stop/mode in,
//          led/busy/step_pulse out (plus pass_cnt with LED_SEQ_PASS_CNT_EN)
// Optional feature macro: LED_SEQ_PASS_CNT_EN adds an 8-bit saturating count
// of completed passes (rotate wrap to bit 0, bounce return to bit 0).
module led_seq
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 1
) (
  input  logic     clk,
  input  logic     rst,
  led_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic             step_pulse_q, step_pulse_d;

  logic             step;
  logic             cnt_enable;
  logic             cnt_clear;
  logic             go_up;
  logic [WIDTH-1:0] adv_led;
  dir_e             adv_dir;
`ifdef LED_SEQ_PASS_CNT_EN
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic             adv_pass;
`endif

  // A stop in RUN suppresses the step and freezes the prescaler that cycle.
  assign cnt_enable = (state_q == RUN) && !bus.stop;
  // Every accepted start (from IDLE or PAUSE) restarts the prescaler.
  assign cnt_clear  = ((state_q == IDLE) || (state_q == PAUSE)) && bus.start && !bus.stop;

  edge_tick #(
    .STEP_DIV(STEP_DIV)
  ) u_edge_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_in(bus.tick_in),
    .enable (cnt_enable),
    .clear  (cnt_clear),
    .step   (step)
  );

  // Next pattern value. In bounce mode the effective direction is forced away
  // from an end bit, so a pattern left at an end by rotate mode (with a stale
  // dir) still bounces back instead of shifting out.
  always_comb begin
    go_up   = ((dir_q == DIR_UP) && !led_q[WIDTH-1]) || led_q[0];
    adv_dir = dir_q;
    if (bus.mode == MODE_ROT) begin
      adv_led = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
    end else begin
      adv_led = go_up ? (led_q << 1) : (led_q >> 1);
      if (adv_led[WIDTH-1]) begin
        adv_dir = DIR_DOWN;
      end else if (adv_led[0]) begin
        adv_dir = DIR_UP;
      end else begin
        adv_dir = go_up ? DIR_UP : DIR_DOWN;
      end
    end
  end

`ifdef LED_SEQ_PASS_CNT_EN
  // A pass completes whenever bit 0 is reached by a rotate wrap or a downward bounce.
  assign adv_pass = adv_led[0] && ((bus.mode == MODE_ROT) || !go_up);
`endif

  // Next-state and pattern register update.
  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
`ifdef LED_SEQ_PASS_CNT_EN
    pass_cnt_d   = pass_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          led_d   = {{(WIDTH-1){1'b0}}, 1'b1};
          dir_d   = DIR_UP;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = PAUSE;
        end else if (step) begin
          led_d        = adv_led;
          dir_d        = adv_dir;
          step_pulse_d = 1'b1;
`ifdef LED_SEQ_PASS_CNT_EN
          if (adv_pass && (pass_cnt_q != 8'hFF)) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
          end
`endif
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
          led_d   = '0;
`ifdef LED_SEQ_PASS_CNT_EN
          pass_cnt_d = '0;
`endif
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      led_q        <= '0;
      dir_q        <= DIR_UP;
      step_pulse_q <= 1'b0;
`ifdef LED_SEQ_PASS_CNT_EN
      pass_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
      step_pulse_q <= step_pulse_d;
`ifdef LED_SEQ_PASS_CNT_EN
      pass_cnt_q   <= pass_cnt_d;
`endif
    end
  end

  // Outputs.
  always_comb begin
    bus.led        = led_q;
    bus.busy       = (state_q == RUN) || (state_q == PAUSE);
    bus.step_pulse = step_pulse_q;
`ifdef LED_SEQ_PASS_CNT_EN
    bus.pass_cnt   = pass_cnt_q;
`endif
  end

endmodule

// File: tb/tb_led_seq.sv
// tb_led_seq -- self-checking bench for led_seq. Two instances share one
// stimulus stream: u_dut0 (WIDTH 8, STEP_DIV 1) and u_dut1 (WIDTH 4, STEP_DIV 3).
// Expected values come from a position/direction model of the sequencer.
// Checks pass_cnt when LED_SEQ_PASS_CNT_EN is defined.
module tb_led_seq;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic tick_in = 1'b0;
  logic start   = 1'b0;
  logic stop    = 1'b0;
  logic mode    = 1'b0;

  always #5 clk = ~clk;

  led_seq_if #(.WIDTH(8)) bus0 ();
  led_seq_if #(.WIDTH(4)) bus1 ();

  assign bus0.tick_in = tick_in;
  assign bus0.start   = start;
  assign bus0.stop    = stop;
  assign bus0.mode    = mode;
  assign bus1.tick_in = tick_in;
  assign bus1.start   = start;
  assign bus1.stop    = stop;
  assign bus1.mode    = mode;

  led_seq #(.WIDTH(8), .STEP_DIV(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  led_seq #(.WIDTH(4), .STEP_DIV(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_checks = 0;
  int n_errors = 0;
  int sp_cnt[2];

  // Reference model: state 0 idle / 1 run / 2 pause, lit LED as an index.
  int m_state[2];
  int m_pos[2];
  bit m_up[2];
  int m_cnt[2];
  bit m_tprev[2];
  int m_pass[2];

  function automatic int mw(int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int md(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] exp_led(int k);
    return (m_state[k] == 0) ? 32'd0 : (32'd1 << m_pos[k]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0;
      m_pos[k]   = 0;
      m_up[k]    = 1'b1;
      m_cnt[k]   = 0;
      m_tprev[k] = 1'b0;
      m_pass[k]  = 0;
    end
  endtask

  task automatic model_advance(input int k, input bit m);
    bit moving_up;
    if (!m) begin
      m_pos[k] = (m_pos[k] + 1) % mw(k);
      if (m_pos[k] == 0 && m_pass[k] < 255) m_pass[k]++;
    end else begin
      // never step past an end, whatever the remembered direction
      moving_up = (m_pos[k] == 0) || (m_up[k] && m_pos[k] != mw(k) - 1);
      m_pos[k] = moving_up ? m_pos[k] + 1 : m_pos[k] - 1;
      if (m_pos[k] == mw(k) - 1)      m_up[k] = 1'b0;
      else if (m_pos[k] == 0)         m_up[k] = 1'b1;
      else                            m_up[k] = moving_up;
      if (m_pos[k] == 0 && !moving_up && m_pass[k] < 255) m_pass[k]++;
    end
  endtask

  task automatic model_clock(input bit t, input bit s, input bit p, input bit m);
    for (int k = 0; k < 2; k++) begin
      bit e;
      e = t && !m_tprev[k];
      m_tprev[k] = t;
      case (m_state[k])
        0: if (s && !p) begin
             m_state[k] = 1; m_pos[k] = 0; m_up[k] = 1'b1; m_cnt[k] = 0;
           end
        1: if (p) m_state[k] = 2;
           else if (e) begin
             if (m_cnt[k] == md(k) - 1) begin
               m_cnt[k] = 0;
               model_advance(k, m);
             end else begin
               m_cnt[k]++;
             end
           end
        default: if (p) begin
             m_state[k] = 0; m_pass[k] = 0;
           end else if (s) begin
             m_state[k] = 1; m_cnt[k] = 0;
           end
      endcase
    end
  endtask

  // One clock: drive inputs, predict, let the edge pass, compare at negedge.
  task automatic cycle(input bit t, input bit s, input bit p, input bit m);
    int pos_before[2];
    int st_before[2];
    bit exp_sp[2];
    tick_in = t; start = s; stop = p; mode = m;
    for (int k = 0; k < 2; k++) begin
      pos_before[k] = m_pos[k];
      st_before[k]  = m_state[k];
    end
    model_clock(t, s, p, m);
    for (int k = 0; k < 2; k++)
      exp_sp[k] = (st_before[k] == 1) && (m_state[k] == 1) &&
                  ((m_pos[k] != pos_before[k]) || (m_cnt[k] == 0 && t && !p && md(k) == 1 && mw(k) == 1));
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("led0",  32'(bus0.led), exp_led(0));
    check("busy0", 32'(bus0.busy), 32'(m_state[0] != 0));
    check("sp0",   32'(bus0.step_pulse), 32'(exp_sp[0]));
    check("led1",  32'(bus1.led), exp_led(1));
    check("busy1", 32'(bus1.busy), 32'(m_state[1] != 0));
    check("sp1",   32'(bus1.step_pulse), 32'(exp_sp[1]));
`ifdef LED_SEQ_PASS_CNT_EN
    check("pass0", 32'(bus0.pass_cnt), 32'(m_pass[0]));
    check("pass1", 32'(bus1.pass_cnt), 32'(m_pass[1]));
`endif
    if (bus0.step_pulse) sp_cnt[0]++;
    if (bus1.step_pulse) sp_cnt[1]++;
  endtask

  task automatic rise(input bit m);
    cycle(1'b1, 1'b0, 1'b0, m);
  endtask

  task automatic rest(input bit m);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, m);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, m);
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("arst_led0",  32'(bus0.led), 32'd0);
    check("arst_busy0", 32'(bus0.busy), 32'd0);
    check("arst_sp0",   32'(bus0.step_pulse), 32'd0);
    check("arst_led1",  32'(bus1.led), 32'd0);
    check("arst_busy1", 32'(bus1.busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int bnc_exp[7];
    int base;
    bit rt, rs, rp, rm;
    bnc_exp = '{2, 4, 8, 4, 2, 1, 2};
    sp_cnt[0] = 0;
    sp_cnt[1] = 0;
    model_reset();

    // Power-on reset
    #1 rst = 1'b0;
    #1;
    check("rst_led0", 32'(bus0.led), 32'd0);
    check("rst_busy0", 32'(bus0.busy), 32'd0);
    check("rst_sp0", 32'(bus0.step_pulse), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Rotate on WIDTH 8
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("rot_start", 32'(bus0.led), 32'h01);
    for (int i = 0; i < 9; i++) begin
      rise(1'b0);
      check("rot_led", 32'(bus0.led), 32'd1 << ((i + 1) % 8));
      check("rot_sp", 32'(bus0.step_pulse), 32'd1);
      rest(1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_led0", 32'(bus0.led), 32'd0);
    check("clr_led1", 32'(bus1.led), 32'd0);

    // Bounce on WIDTH 4 / STEP_DIV 3
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("bnc_start", 32'(bus1.led), 32'h1);
    base = sp_cnt[1];
    for (int i = 0; i < 21; i++) begin
      rise(1'b1);
      if (i % 3 == 2) check("bnc_led", 32'(bus1.led), 32'(bnc_exp[i / 3]));
      if (i == 5) check("div3_steps", 32'(sp_cnt[1] - base), 32'd2);
      rest(1'b1);
    end

    // Level held high gives a single edge
    base = sp_cnt[0];
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("hold_edges", 32'(sp_cnt[0] - base), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Pause / resume / clear
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    rise(1'b0); rest(1'b0);
    rise(1'b0); rest(1'b0);
    check("pre_pause", 32'(bus0.led), 32'h04);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rise(1'b0);
      check("pause_led", 32'(bus0.led), 32'h04);
      rest(1'b0);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    rise(1'b0);
    check("resume_led", 32'(bus0.led), 32'h08);
    rest(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_led", 32'(bus0.led), 32'd0);
    check("idle_busy", 32'(bus0.busy), 32'd0);

    // Collisions
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("ss_busy", 32'(bus0.busy), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("stopstep_led", 32'(bus0.led), 32'h01);
    check("stopstep_sp", 32'(bus0.step_pulse), 32'd0);
    check("stopstep_busy", 32'(bus0.busy), 32'd1);
    rest(1'b0);

    // Reset mid-RUN
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin rise(1'b1); rest(1'b1); end
    rise(1'b1);
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_busy", 32'(bus0.busy), 32'd0);

    // Randomised traffic
    rt = 1'b0;
    rm = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rt = ~rt;
      if ($urandom_range(0, 39) == 0) rm = ~rm;
      rs = ($urandom_range(0, 15) == 0);
      rp = ($urandom_range(0, 19) == 0);
      cycle(rt, rs, rp, rm);
      if ($urandom_range(0, 599) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_seq.md
Name: led_seq

Overview:
- Downstream consumer of the clock-divider square wave.
- Detects each rising edge of the divider output and prescales the edges into step events.
- Drives a WIDTH-bit one-hot LED pattern: rotate or bounce ("Knight Rider").
- Run/pause/stop control via single-cycle command pulses; one synchronous clock domain shared with the divider.

Parameters:
- WIDTH, 8, number of LEDs; legal range 2..32.
- STEP_DIV, 1, divider-output rising edges per pattern step; legal range 1..16.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- tick_in  in  1  divider square-wave output; registered on clk upstream, so no synchroniser needed.
- start  in  1  one-cycle command pulse: start or resume.
- stop  in  1  one-cycle command pulse: pause, or clear when already paused.
- mode  in  1  0 = rotate left, 1 = bounce.
- led  out  WIDTH  one-hot pattern (all zero in IDLE).
- busy  out  1  high in RUN and PAUSE.
- step_pulse  out  1  high for exactly the cycle in which led takes a new step value.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, led = 0, busy = 0, step_pulse = 0.
  - tick_d = 0, edge_cnt = 0, dir = up.
- Edge detect:
  - tick_d <= tick_in every cycle.
  - edge = tick_in & ~tick_d.
  - A level held high gives one edge only.
- Prescaler:
  - edge_cnt counts edges 0..STEP_DIV-1, in RUN only.
  - step = edge & (edge_cnt == STEP_DIV-1); edge_cnt wraps to 0 on step.
  - edge_cnt is cleared on every entry to RUN.
- Latency: the first clk edge at which tick_in = 1 and tick_d = 0 updates led and asserts step_pulse. That is 1 cycle after tick_in rises.
- State machine IDLE / RUN / PAUSE:
  - IDLE: led = 0. On start: go to RUN, led = 1 (bit 0), dir = up, edge_cnt = 0. stop is ignored.
  - RUN: on stop, go to PAUSE with led held. Otherwise, on step, advance the pattern. start is ignored.
  - PAUSE: led held and edges ignored. On start: go to RUN, edge_cnt = 0, led and dir kept. On stop: go to IDLE, led = 0.
- Simultaneous start and stop: stop wins in every state.
- A step and a stop in the same cycle: stop wins, no step is taken, and step_pulse = 0.
- An edge in the cycle start is accepted is not counted.
- Rotate (mode = 0): led <= {led[WIDTH-2:0], led[WIDTH-1]}. Bit WIDTH-1 wraps to bit 0.
- Bounce (mode = 1):
  - dir up: shift left. On reaching bit WIDTH-1, set dir = down.
  - dir down: shift right. On reaching bit 0, set dir = up.
  - The end bits are lit for one step only (no double dwell).
- mode is sampled only on a step.
  - Switching to rotate while dir = down continues with a left rotate from the current position.
  - dir is kept so bounce can resume later.
- led must stay one-hot in RUN/PAUSE and zero in IDLE under all sequences.

Optional Feature:
- Macro: LED_SEQ_PASS_CNT_EN.
- Defined: extra output pass_cnt [7:0].
  - Increments on a rotate wrap (bit WIDTH-1 to bit 0).
  - Increments on a bounce return to bit 0.
  - Saturates at 255; cleared on reset and on entry to IDLE.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Package led_seq_pkg holds:
  - state encodings: IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2.
  - mode encodings: MODE_ROT = 1'b0, MODE_BOUNCE = 1'b1.
  - direction constants.
- Sub-module edge_tick:
  - contents: tick_in register, rising-edge detect and STEP_DIV prescaler.
  - inputs: enable, clear.
  - output: one-cycle step.
- led_seq holds the FSM and the pattern register.

Test Plan:
- Reset mid-RUN: assert rst = 0 asynchronously between clk edges → led = 0, busy = 0, step_pulse = 0 immediately; after release, state = IDLE.
- Rotate, WIDTH = 8, STEP_DIV = 1, tick_in toggling every 5 cycles: start → led = 0x01. Successive steps give 0x02, 0x04 … 0x80, 0x01, with step_pulse one cycle after each tick_in rise.
- Bounce, WIDTH = 4: start, then 7 steps → led = 0x1, 0x2, 0x4, 0x8, 0x4, 0x2, 0x1, 0x2.
- STEP_DIV = 3: 6 tick_in rises → exactly 2 steps; tick_in held high for 20 cycles → 1 edge only.
- Pause/clear: RUN at led = 0x04, stop → led stays 0x04 through 4 edges. start → next step gives 0x08. stop, stop → IDLE, led = 0.
- Collisions: start & stop in the same cycle from IDLE → stays IDLE. stop coinciding with a step in RUN → PAUSE, led unchanged, step_pulse = 0.
